spart_echo_system: RTL and testbench
====================================

// Module: spart_echo_system
// PURPOSE
//  Top of the serial echo system: a SPART (UART with 16x-oversampling baud generator) and its bus driver.
//  The two talk over an internal 8-bit parallel I/O bus. After reset the driver programs the baud
//  divisor selected by br_cfg, then echoes every received byte back out on txd.
//  Frame format is 8N1, LSB first. Fixed internal partition: spart (UART core) + driver (bus-master FSM).
// PARAMETERS
//  DB_4800   16'd1301  divisor for br_cfg=00 (100 MHz clk)
//  DB_9600   16'd650   divisor for br_cfg=01
//  DB_19200  16'd325   divisor for br_cfg=10
//  DB_38400  16'd162   divisor for br_cfg=11
// PORTS
//  clk     in   1  100 MHz system clock; single clock domain
//  rst     in   1  reset, synchronous, active-high
//  txd     out  1  RS232 transmit data, idle high
//  rxd     in   1  RS232 receive data, asynchronous, idle high
//  br_cfg  in   2  baud-rate select (DIP switches)
// BEHAVIOUR
//  Internal bus: iocs, iorw (1=read), ioaddr[1:0], databus[7:0] (bidir), rda, tbr.
//   - spart drives databus only when iocs&iorw; the driver drives it only when iocs&~iorw; else Z.
//  ioaddr map:
//   - 00: read = Rx buffer (clears rda); write = Tx buffer
//   - 01: read = status {6'b0,tbr,rda}
//   - 10: write = DB low byte
//   - 11: write = DB high byte
//   - Each access is a single-cycle strobe.
//  Baud gen: 16-bit down-counter reloads from DB on reaching 0 and emits a 1-cycle tick there,
//   giving a tick period of DB+1 clks. One bit = 16 ticks. DB writes take effect at the next reload.
//  Tx:
//   - A write when tbr=1 loads {stop=1,data,start=0} and clears tbr. A write while tbr=0 is ignored.
//   - txd shifts one bit per 16 ticks. tbr returns to 1 after the full stop bit.
//  Rx:
//   - rxd passes through a 2-flop synchronizer.
//   - A falling edge while idle starts the frame. The line is re-sampled 8 ticks later (mid start bit);
//     if it is high, abort (glitch) and return to idle.
//   - Data bits are sampled every 16 ticks, LSB first, then the stop bit.
//   - Stop=1: latch the byte and set rda. Stop=0: discard the byte (framing error) and leave rda unchanged.
//   - Overrun: a new byte overwrites the buffer and rda stays 1.
//  Driver FSM states:
//   - CFG_LO: write DB[7:0] for br_cfg
//   - CFG_HI: write DB[15:8]
//   - POLL: wait rda=1
//   - READ: iocs=1, iorw=1, ioaddr=00; latch databus
//   - WAIT_TBR: wait tbr=1
//   - WRITE: iocs=1, iorw=0, ioaddr=00, drive the latched byte; then POLL
//   - br_cfg is captured in CFG_LO. If br_cfg differs from the captured value while in POLL, go back to CFG_LO.
//  Reset values:
//   - txd=1, tbr=1, rda=0, Rx/Tx idle, DB=DB_9600, counter cleared
//   - driver in CFG_LO, iocs=0, databus released
//   - Reset mid-frame aborts both Rx and Tx at once; txd=1 on the next clk.
//  Latency:
//   - rda rises within 2 clks of the mid-stop-bit sample.
//   - The echo start bit begins at most 16 ticks + 6 clks after rda rises.
// TESTING
//  1 Reset: rst=1 for 3 clks -> txd=1 throughout; no txd activity for 1 ms with rxd=1.
//  2 Echo 'E': br_cfg=01, send 0x45 on rxd at 104160 ns/bit (0,1,0,1,0,0,0,1,0,1)
//    -> txd carries the same frame, 0x45, at the same bit time.
//  3 br_cfg=11: send 0xA5 at 26080 ns/bit -> echo 0xA5. Change br_cfg to 00 while idle
//    -> the next echo uses 208320 ns/bit.
//  4 Glitch: rxd low for 2 µs at 9600 -> no rda, no txd activity. Framing: stop bit=0 -> no echo.
//  5 Back-to-back: bytes 0x00, 0xFF, 0x55 with 1 stop bit each -> three echoes in order, no loss.
//  6 Reset mid-echo: assert rst halfway through the Tx frame -> txd=1 next clk; a fresh byte is echoed after release.

Source files
------------

// File: rtl/spart_echo_system_if.sv
// Serial-side connection of the echo system.
//   txd    : RS232 transmit data, idle high (driven by the system)
//   rxd    : RS232 receive data, asynchronous, idle high (driven by the line)
//   br_cfg : baud-rate select (DIP switches)
// slave  : view used by spart_echo_system
// master : view used by whatever drives the line and switches
interface spart_echo_system_if;
  logic       txd;
  logic       rxd;
  logic [1:0] br_cfg;

  modport master (input txd, output rxd, output br_cfg);
  modport slave  (output txd, input rxd, input br_cfg);
endinterface

// File: rtl/spart_echo_system.sv
// Serial echo system: SPART (UART core with 16x baud generator) plus a
// bus-master driver that programs the divisor and echoes every received byte.
//
// spart_echo_spart ports:
//   clk, rst          : clock, synchronous active-high reset
//   iocs, iorw, ioaddr: single-cycle bus strobe (iorw=1 read)
//   databus           : resolved internal data bus (input view)
//   rd_data           : value the spart places on the bus during reads
//   rda, tbr          : receive data available, transmit buffer ready
//   txd, rxd          : serial lines
// spart_echo_driver ports:
//   clk, rst, br_cfg  : clock, reset, baud select
//   rda, tbr, databus : status lines and resolved bus
//   iocs, iorw, ioaddr, wr_data : registered bus master outputs
// spart_echo_system ports:
//   clk, rst : clock, synchronous active-high reset
//   ser      : txd / rxd / br_cfg

// Tx FSM: state | meaning
//   TX_IDLE  | tbr=1, txd=1, waiting for a write to address 00
//   TX_ARM   | byte loaded, start bit begins on the next tick
//   TX_SHIFT | shifting start, 8 data, stop; 16 ticks per bit
// Rx FSM: state | meaning
//   RX_IDLE  | waiting for a falling edge on synchronized rxd
//   RX_START | counting 8 ticks to mid start bit
//   RX_DATA  | sampling 8 data bits, LSB first, every 16 ticks
//   RX_STOP  | sampling the stop bit
module spart_echo_spart #(
  parameter logic [15:0] DB_RESET = 16'd650
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] databus,
  output logic [7:0] rd_data,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  typedef enum logic [1:0] {TX_IDLE, TX_ARM, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        wr_stb, rd_stb;
  logic [15:0] db, baud_cnt;
  logic        tick;

  tx_state_t   tx_state;
  logic [8:0]  tx_shift;
  logic [3:0]  tx_ticks, tx_bits;

  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [3:0]  rx_ticks;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_shift, rx_buf;

  assign wr_stb = iocs & ~iorw;
  assign rd_stb = iocs & iorw;

  always_comb begin
    rd_data = 8'h00;
    case (ioaddr)
      2'b00:   rd_data = rx_buf;
      2'b01:   rd_data = {6'b0, tbr, rda};
      default: rd_data = 8'h00;
    endcase
  end

  // Divisor registers; the counter only picks them up on reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      db <= DB_RESET;
    end else if (wr_stb && ioaddr == 2'b10) begin
      db[7:0] <= databus;
    end else if (wr_stb && ioaddr == 2'b11) begin
      db[15:8] <= databus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= 16'd0;
      tick     <= 1'b0;
    end else if (baud_cnt == 16'd0) begin
      baud_cnt <= db;
      tick     <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
      tick     <= 1'b0;
    end
  end

  // Start bit is aligned to a tick so every bit lasts exactly 16 ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= 9'd0;
      tx_ticks <= 4'd0;
      tx_bits  <= 4'd0;
      txd      <= 1'b1;
      tbr      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (wr_stb && ioaddr == 2'b00) begin
            tx_shift <= {1'b1, databus};
            tbr      <= 1'b0;
            tx_state <= TX_ARM;
          end
        end
        TX_ARM: begin
          if (tick) begin
            txd      <= 1'b0;
            tx_ticks <= 4'd15;
            tx_bits  <= 4'd9;
            tx_state <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tick) begin
            if (tx_ticks != 4'd0) begin
              tx_ticks <= tx_ticks - 4'd1;
            end else begin
              tx_ticks <= 4'd15;
              if (tx_bits == 4'd0) begin
                txd      <= 1'b1;
                tbr      <= 1'b1;
                tx_state <= TX_IDLE;
              end else begin
                txd      <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[8:1]};
                tx_bits  <= tx_bits - 4'd1;
              end
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_ticks <= 4'd0;
      rx_bits  <= 3'd0;
      rx_shift <= 8'd0;
      rx_buf   <= 8'd0;
      rda      <= 1'b0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      // A byte landing in the same cycle as the buffer read wins below.
      if (rd_stb && ioaddr == 2'b00) rda <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_ticks <= 4'd7;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_ticks != 4'd0) begin
              rx_ticks <= rx_ticks - 4'd1;
            end else if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_ticks <= 4'd15;
              rx_bits  <= 3'd7;
              rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_ticks != 4'd0) begin
              rx_ticks <= rx_ticks - 4'd1;
            end else begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
              rx_ticks <= 4'd15;
              if (rx_bits == 3'd0) rx_state <= RX_STOP;
              else                 rx_bits  <= rx_bits - 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_ticks != 4'd0) begin
              rx_ticks <= rx_ticks - 4'd1;
            end else begin
              rx_state <= RX_IDLE;
              if (rx_s2) begin
                rx_buf <= rx_shift;
                rda    <= 1'b1;
              end
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// Driver FSM: state | meaning
//   CFG_LO   | capture br_cfg, issue write of DB low byte
//   CFG_HI   | issue write of DB high byte
//   POLL     | wait for rda; reconfigure if br_cfg moved
//   READ     | read strobe on the bus, latch the received byte
//   WAIT_TBR | wait for the transmitter to be free
//   WRITE    | write strobe carrying the latched byte
// Outputs are registered, so each strobe is visible during the state
// that follows the one that requested it.
module spart_echo_driver #(
  parameter logic [15:0] DB_4800  = 16'd1301,
  parameter logic [15:0] DB_9600  = 16'd650,
  parameter logic [15:0] DB_19200 = 16'd325,
  parameter logic [15:0] DB_38400 = 16'd162
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  input  logic [7:0] databus,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] wr_data
);
  typedef enum logic [2:0] {CFG_LO, CFG_HI, POLL, READ, WAIT_TBR, WRITE} drv_state_t;

  drv_state_t  state;
  logic [1:0]  cfg_q;
  logic [7:0]  db_hi_q;
  logic [15:0] db_sel;

  always_comb begin
    db_sel = DB_9600;
    case (br_cfg)
      2'b00:   db_sel = DB_4800;
      2'b01:   db_sel = DB_9600;
      2'b10:   db_sel = DB_19200;
      default: db_sel = DB_38400;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CFG_LO;
      iocs    <= 1'b0;
      iorw    <= 1'b1;
      ioaddr  <= 2'b00;
      wr_data <= 8'h00;
      cfg_q   <= 2'b00;
      db_hi_q <= 8'h00;
    end else begin
      case (state)
        CFG_LO: begin
          cfg_q   <= br_cfg;
          db_hi_q <= db_sel[15:8];
          iocs    <= 1'b1;
          iorw    <= 1'b0;
          ioaddr  <= 2'b10;
          wr_data <= db_sel[7:0];
          state   <= CFG_HI;
        end
        CFG_HI: begin
          ioaddr  <= 2'b11;
          wr_data <= db_hi_q;
          state   <= POLL;
        end
        POLL: begin
          iocs <= 1'b0;
          iorw <= 1'b1;
          if (br_cfg != cfg_q) begin
            state <= CFG_LO;
          end else if (rda) begin
            iocs   <= 1'b1;
            ioaddr <= 2'b00;
            state  <= READ;
          end
        end
        READ: begin
          wr_data <= databus;
          iocs    <= 1'b0;
          state   <= WAIT_TBR;
        end
        WAIT_TBR: begin
          if (tbr) begin
            iocs   <= 1'b1;
            iorw   <= 1'b0;
            ioaddr <= 2'b00;
            state  <= WRITE;
          end
        end
        WRITE: begin
          iocs  <= 1'b0;
          iorw  <= 1'b1;
          state <= POLL;
        end
        default: state <= CFG_LO;
      endcase
    end
  end
endmodule

module spart_echo_system #(
  parameter logic [15:0] DB_4800  = 16'd1301,
  parameter logic [15:0] DB_9600  = 16'd650,
  parameter logic [15:0] DB_19200 = 16'd325,
  parameter logic [15:0] DB_38400 = 16'd162
) (
  input logic               clk,
  input logic               rst,
  spart_echo_system_if.slave ser
);
  logic       iocs, iorw, rda, tbr, txd;
  logic [1:0] ioaddr;
  logic [7:0] rd_data, wr_data;
  wire  [7:0] databus;

  // Only one side ever drives the bus; idle cycles leave it floating.
  assign databus = (iocs &  iorw) ? rd_data :
                   (iocs & ~iorw) ? wr_data : 8'bz;

  assign ser.txd = txd;

  spart_echo_spart #(.DB_RESET(DB_9600)) u_spart (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rd_data (rd_data),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (ser.rxd)
  );

  spart_echo_driver #(
    .DB_4800  (DB_4800),
    .DB_9600  (DB_9600),
    .DB_19200 (DB_19200),
    .DB_38400 (DB_38400)
  ) u_driver (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (ser.br_cfg),
    .rda     (rda),
    .tbr     (tbr),
    .databus (databus),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .wr_data (wr_data)
  );
endmodule

// File: tb/tb_spart_echo_system.sv
// Bench for spart_echo_system. Divisors are scaled down so whole frames fit
// in a short run; bit time is 16*(DB+1) clocks either way.
module tb_spart_echo_system;
  localparam logic [15:0] TB_DB_4800  = 16'd31;
  localparam logic [15:0] TB_DB_9600  = 16'd15;
  localparam logic [15:0] TB_DB_19200 = 16'd7;
  localparam logic [15:0] TB_DB_38400 = 16'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spart_echo_system_if ser();

  spart_echo_system #(
    .DB_4800  (TB_DB_4800),
    .DB_9600  (TB_DB_9600),
    .DB_19200 (TB_DB_19200),
    .DB_38400 (TB_DB_38400)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ser (ser)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] exp_q[$];
  int   cur_bc = 256;
  bit   dec_busy = 1'b0;
  logic rst_q = 1'b0;
  logic txd_prev = 1'b1;
  int   low_run = 0;
  int   last_low_w = 0;
  int   start_w = 0;
  logic [7:0] last_echo = 8'h00;

  function automatic int bit_clks(input logic [1:0] cfg);
    logic [15:0] d;
    case (cfg)
      2'b00:   d = TB_DB_4800;
      2'b01:   d = TB_DB_9600;
      2'b10:   d = TB_DB_19200;
      default: d = TB_DB_38400;
    endcase
    return 16 * (int'(d) + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rst_q <= rst;

  // Length of the most recent completed low run on txd, in clocks.
  always @(negedge clk) begin
    if (rst) low_run = 0;
    else if (ser.txd === 1'b0) low_run++;
    else if (low_run != 0) begin
      last_low_w = low_run;
      low_run = 0;
    end
  end

  task automatic wait_neg(input int n, inout bit ab);
    for (int k = 0; k < n && !ab; k++) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Output checker: txd must idle high whenever no echo is owed, must be high
  // after any reset clock, and each echo frame must match the next owed byte.
  initial begin : monitor
    logic [7:0] exp_b, got;
    logic       stop_b;
    int         bc;
    bit         ab;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        check("reset_txd", {31'b0, ser.txd}, 32'd1);
        txd_prev = 1'b1;
      end else if (rst) begin
        txd_prev = 1'b1;
      end else if (txd_prev === 1'b1 && ser.txd === 1'b0 && exp_q.size() != 0) begin
        dec_busy = 1'b1;
        exp_b = exp_q.pop_front();
        bc = cur_bc;
        ab = 1'b0;
        got = 8'h00;
        wait_neg(bc / 2, ab);
        if (!ab) check("start_bit", {31'b0, ser.txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          wait_neg(bc, ab);
          got[i] = ser.txd;
          if (i == 0) start_w = last_low_w;
        end
        wait_neg(bc, ab);
        stop_b = ser.txd;
        if (!ab) begin
          check("echo_byte", {24'b0, got}, {24'b0, exp_b});
          check("stop_bit", {31'b0, stop_b}, 32'd1);
          last_echo = got;
        end
        txd_prev = ab ? 1'b1 : ser.txd;
        dec_busy = 1'b0;
      end else begin
        if (exp_q.size() == 0 && !dec_busy) check("idle_txd", {31'b0, ser.txd}, 32'd1);
        txd_prev = ser.txd;
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_val);
    int bc;
    bc = cur_bc;
    ser.rxd = 1'b0;
    clks(bc);
    for (int i = 0; i < 8; i++) begin
      ser.rxd = d[i];
      clks(bc);
    end
    if (stop_val) exp_q.push_back(d);
    ser.rxd = stop_val;
    clks(bc);
    ser.rxd = 1'b1;
    if (!stop_val) clks(bc);
  endtask

  task automatic send_glitch();
    ser.rxd = 1'b0;
    clks(3 * cur_bc / 16);
    ser.rxd = 1'b1;
    clks(cur_bc);
  endtask

  task automatic drain();
    for (int k = 0; k < 15000 && (exp_q.size() != 0 || dec_busy); k++) @(negedge clk);
    check("drain_done", {31'b0, (exp_q.size() == 0 && !dec_busy)}, 32'd1);
    clks(cur_bc);
  endtask

  task automatic set_cfg(input logic [1:0] c);
    ser.br_cfg = c;
    cur_bc = bit_clks(c);
    clks(200);
  endtask

  initial begin : stim
    logic [7:0] d;
    int kind;
    ser.rxd = 1'b1;
    ser.br_cfg = 2'b01;
    cur_bc = bit_clks(2'b01);
    rst = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(1000);

    send_frame(8'h45, 1'b1);
    drain();
    check("echo_45", {24'b0, last_echo}, 32'h45);
    check("bit_cfg01", start_w, 256);

    set_cfg(2'b11);
    send_frame(8'hA5, 1'b1);
    drain();
    check("echo_a5", {24'b0, last_echo}, 32'hA5);
    check("bit_cfg11", start_w, 64);

    set_cfg(2'b00);
    send_frame(8'h45, 1'b1);
    drain();
    check("bit_cfg00", start_w, 512);

    set_cfg(2'b01);
    send_glitch();
    clks(3 * cur_bc);
    send_frame(8'h3C, 1'b0);
    clks(3 * cur_bc);
    send_frame(8'h13, 1'b1);
    drain();
    check("echo_after_errors", {24'b0, last_echo}, 32'h13);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    drain();
    check("b2b_last", {24'b0, last_echo}, 32'h55);

    send_frame(8'h81, 1'b1);
    for (int k = 0; k < 5000 && !dec_busy; k++) @(negedge clk);
    check("echo_started", {31'b0, dec_busy}, 32'd1);
    clks(5 * cur_bc);
    rst = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(50);
    send_frame(8'h7E, 1'b1);
    drain();
    check("echo_after_reset", {24'b0, last_echo}, 32'h7E);

    for (int n = 0; n < 10; n++) begin
      if (n % 4 == 0) begin
        drain();
        set_cfg(2'($urandom_range(0, 3)));
      end
      kind = int'($urandom_range(0, 9));
      d = 8'($urandom);
      if (kind < 8)       send_frame(d, 1'b1);
      else if (kind == 8) send_frame(d, 1'b0);
      else                send_glitch();
      clks(int'($urandom_range(0, cur_bc)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
